axi_lite_dmem: RTL and testbench
================================

// Module: axi_lite_dmem
// PURPOSE
//  Data-memory AXI4-Lite slave directly downstream of the writeback/memory-access stage.
//  Serves one outstanding read (AR/R) and one outstanding write (AW/W/B) per channel group.
//  Backing store is a word-addressed register array. Read and write latency are configurable.
//  Master behaviour it serves:
//    - the master holds valid until the response handshake;
//    - the master asserts rready/bready together with arvalid/awvalid.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words in the array
//  BASE_ADDR    32'h8000_0000 byte address of word 0
//  READ_LAT     2             extra wait cycles between AR accept and rvalid (0..255)
//  WRITE_LAT    2             extra wait cycles between AW+W capture and bvalid (0..255)
// PORTS
//  clk      in   1   clock
//  rst      in   1   synchronous active-high reset
//  araddr   in   32  read byte address
//  arvalid  in   1   read address valid
//  arready  out  1   read address ready
//  rdata    out  32  read data, full aligned word
//  rresp    out  2   00 = OKAY, 11 = DECERR
//  rvalid   out  1   read data valid
//  rready   in   1   read data ready
//  awaddr   in   32  write byte address
//  awvalid  in   1   write address valid
//  awready  out  1   write address ready
//  wdata    in   32  write data
//  wstrb    in   8   byte strobes; [3:0] map to wdata bytes 0..3, [7:4] ignored
//  wvalid   in   1   write data valid
//  wready   out  1   write data ready
//  bresp    out  2   00 = OKAY, 11 = DECERR
//  bvalid   out  1   write response valid
//  bready   in   1   write response ready
// BEHAVIOUR
//  - Address decode: idx = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
//    In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
//  - Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE:
//    - arready = (state == R_IDLE).
//    - On arvalid & arready: latch idx and range flag, load 8-bit cnt = READ_LAT, go to R_WAIT.
//    - R_WAIT: cnt != 0 -> decrement. cnt == 0 -> register rdata/rresp, set rvalid, go to R_RESP.
//    - Result: rvalid rises READ_LAT+1 cycles after the AR handshake edge.
//    - R_RESP: hold rvalid/rdata/rresp stable until rready. On rvalid & rready: clear rvalid, go to R_IDLE.
//    - arready returns the cycle after the R handshake, so there is no back-to-back AR accept.
//  - Write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE:
//    - awready = W_IDLE & !aw_got; wready = W_IDLE & !w_got.
//    - AW and W may arrive in either order or together. Each is captured once into a holding register with its got-flag set.
//    - When both flags are set: load cnt = WRITE_LAT, clear both flags, go to W_WAIT.
//    - W_WAIT: cnt == 0 -> commit bytes where wstrb[i] is 1 (if in range), set bvalid/bresp, go to W_RESP.
//    - Result: bvalid rises WRITE_LAT+1 cycles after the later of the AW and W captures.
//    - W_RESP: hold bvalid until bready. On bvalid & bready: clear bvalid, go to W_IDLE.
//    - Master still driving awvalid/wvalid after capture is ignored, because the readys are low.
//  - Out of range:
//    - read: rdata = 0, rresp = 11;
//    - write: array unchanged, bresp = 11. No other side effects.
//  - Simultaneous read sample and write commit to the same word in the same cycle:
//    read returns the OLD word; the new value is visible to the next read.
//  - The read and write FSMs are fully independent; both may be busy at once.
//  - Reset values: rvalid = 0, bvalid = 0, rdata = 0, rresp = 00, bresp = 00.
//    Both FSMs go to IDLE, cnts and got-flags clear, arready/awready/wready = 1 after reset.
//  - Reset mid-transaction:
//    - the in-flight transaction is abandoned with no response;
//    - an uncommitted write is dropped;
//    - array contents are not reset (initialised to 0 by simulation init only).
// TESTING
//  - Write then read (READ_LAT = WRITE_LAT = 2):
//    - AW = 8000_0010, W = DEADBEEF, wstrb = 0F -> bvalid 3 cycles after capture, bresp = 00;
//    - AR = 8000_0010 -> rvalid 3 cycles after accept, rdata = DEADBEEF, rresp = 00.
//  - Byte strobe over DEADBEEF at 8000_0010:
//    - wstrb = 04, wdata = 0055_0000 -> read returns DE55BEEF;
//    - wstrb = F0 -> word unchanged, bresp = 00.
//  - Order and backpressure:
//    - W arrives 3 cycles before AW -> wready drops after W capture, commit only after AW;
//    - bready held low 4 cycles -> bvalid stays 1, then clears on the cycle after the handshake;
//    - same for rready on reads, with rdata held stable throughout.
//  - Decode error:
//    - AR = 7FFF_FFFC -> rresp = 11, rdata = 0;
//    - AW = BASE + 4*DEPTH_WORDS, W = 1234 -> bresp = 11, and no in-range word changes.
//  - Concurrency and reset:
//    - read and write to the same word, with rvalid-rise and commit in the same cycle -> old data returned;
//    - rst pulsed during R_WAIT -> rvalid never rises, arready = 1 the next cycle;
//    - READ_LAT = 0 -> rvalid the cycle after the AR handshake.

Source files
------------

// File: rtl/axi_lite_dmem.sv
// AXI4-Lite data-memory slave: word-addressed array behind independent read and
// write FSMs, each with one outstanding transaction and a programmable response delay.
module axi_lite_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned READ_LAT    = 2,
    parameter int unsigned WRITE_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [7:0]  RLAT  = 8'(READ_LAT);
    localparam logic [7:0]  WLAT  = 8'(WRITE_LAT);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

    logic [31:0] r_mem [DEPTH_WORDS];

    // Offsets below BASE_ADDR wrap to huge values, so one unsigned compare covers both bounds.
    logic [31:0] w_ar_off;
    logic [31:0] w_aw_off;
    logic        w_ar_in;
    logic        w_aw_in;
    logic        w_unused_strb;

    assign w_ar_off      = araddr - BASE_ADDR;
    assign w_aw_off      = awaddr - BASE_ADDR;
    assign w_ar_in       = ({1'b0, w_ar_off} < SPAN);
    assign w_aw_in       = ({1'b0, w_aw_off} < SPAN);
    assign w_unused_strb = ^wstrb[7:4];

    rstate_t             r_rstate;
    rstate_t             w_rstate_nxt;
    logic [IDX_W-1:0]    r_ridx;
    logic                r_rin;
    logic [7:0]          r_rcnt;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rvalid;
    logic                w_ar_hs;
    logic                w_r_fire;

    assign w_ar_hs  = arvalid && (r_rstate == R_IDLE);
    assign w_r_fire = (r_rstate == R_WAIT) && (r_rcnt == 8'd0);

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (arvalid) w_rstate_nxt = R_WAIT;
            R_WAIT:  if (r_rcnt == 8'd0) w_rstate_nxt = R_RESP;
            R_RESP:  if (rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= 8'd0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'b00;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs)
                r_rcnt <= RLAT;
            else if ((r_rstate == R_WAIT) && (r_rcnt != 8'd0))
                r_rcnt <= r_rcnt - 8'd1;
            if (w_r_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_rin ? r_mem[r_ridx] : 32'd0;
                r_rresp  <= r_rin ? 2'b00 : 2'b11;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ar_hs) begin
            r_ridx <= w_ar_off[IDX_W+1:2];
            r_rin  <= w_ar_in;
        end
    end

    wstate_t             r_wstate;
    wstate_t             w_wstate_nxt;
    logic                r_aw_got;
    logic                r_w_got;
    logic [IDX_W-1:0]    r_widx;
    logic                r_win;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic [7:0]          r_wcnt;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                w_awready;
    logic                w_wready;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_both;
    logic                w_commit;

    assign w_awready = (r_wstate == W_IDLE) && !r_aw_got;
    assign w_wready  = (r_wstate == W_IDLE) && !r_w_got;
    assign w_aw_hs   = awvalid && w_awready;
    assign w_w_hs    = wvalid && w_wready;
    // Launch on the edge that completes the pair, so latency counts from the later capture.
    assign w_both    = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
    assign w_commit  = (r_wstate == W_WAIT) && (r_wcnt == 8'd0);

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_both) w_wstate_nxt = W_WAIT;
            W_WAIT:  if (r_wcnt == 8'd0) w_wstate_nxt = W_RESP;
            W_RESP:  if (bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_wcnt   <= 8'd0;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_both) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
                r_wcnt   <= WLAT;
            end else begin
                if (w_aw_hs) r_aw_got <= 1'b1;
                if (w_w_hs)  r_w_got  <= 1'b1;
                if ((r_wstate == W_WAIT) && (r_wcnt != 8'd0))
                    r_wcnt <= r_wcnt - 8'd1;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= r_win ? 2'b00 : 2'b11;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_widx <= w_aw_off[IDX_W+1:2];
            r_win  <= w_aw_in;
        end
        if (w_w_hs) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb[3:0];
        end
    end

    // A reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_win) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i])
                    r_mem[r_widx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign arready = (r_rstate == R_IDLE);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rvalid  = r_rvalid;
    assign awready = w_awready;
    assign wready  = w_wready;
    assign bresp   = r_bresp;
    assign bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi_lite_dmem.sv
// Bench for axi_lite_dmem: directed vector table, randomized traffic against a
// word-array reference model, and hand sequences for concurrency, reset and zero latency.
module tb_axi_lite_dmem;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [7:0]  wstrb = '0;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [1:0]  rresp, bresp;

    logic [31:0] z_araddr = '0, z_awaddr = '0, z_wdata = '0, z_rdata;
    logic        z_arvalid = 1'b0, z_rready = 1'b0, z_awvalid = 1'b0, z_wvalid = 1'b0, z_bready = 1'b0;
    logic [7:0]  z_wstrb = '0;
    logic        z_arready, z_rvalid, z_awready, z_wready, z_bvalid;
    logic [1:0]  z_rresp, z_bresp;

    axi_lite_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LAT(2), .WRITE_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_lite_dmem #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .READ_LAT(0), .WRITE_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .araddr(z_araddr), .arvalid(z_arvalid), .arready(z_arready),
        .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(z_rready),
        .awaddr(z_awaddr), .awvalid(z_awvalid), .awready(z_awready),
        .wdata(z_wdata), .wstrb(z_wstrb), .wvalid(z_wvalid), .wready(z_wready),
        .bresp(z_bresp), .bvalid(z_bvalid), .bready(z_bready)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    // Reference model: sparse word store, bytes merged under strobe.
    logic [31:0] model [int];

    function automatic bit in_rng(input logic [31:0] a);
        return ({32'd0, a} >= {32'd0, BASE}) && ({32'd0, a} < {32'd0, BASE} + 64'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!in_rng(a)) return 32'd0;
        return model.exists(widx(a)) ? model[widx(a)] : 32'd0;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        logic [31:0] w;
        if (!in_rng(a)) return;
        w = model_rd(a);
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model[widx(a)] = w;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] r, output int lat);
        int n;
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        n = 0;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        chkb("arready before AR", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 300) begin @(posedge clk); #1; lat++; end
        chkb("rvalid arrives", rvalid, 1'b1);
        d = rdata; r = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chkb("rvalid held under backpressure", rvalid, 1'b1);
            chk("rdata stable under backpressure", rdata, d);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chkb("rvalid clears after R handshake", rvalid, 1'b0);
        chkb("arready back after R handshake", arready, 1'b1);
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first; gap = cycles between captures.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                             input int order, input int gap, input int hold,
                             output logic [1:0] r, output int lat);
        awaddr = a; wdata = d; wstrb = s; bready = (hold == 0);
        if (order == 0) begin awvalid = 1'b1; wvalid = 1'b1; end
        else if (order == 1) wvalid = 1'b1;
        else awvalid = 1'b1;
        @(posedge clk); #1;
        if (order != 0) begin
            if (order == 1) begin
                chkb("wready low after W capture", wready, 1'b0);
                chkb("awready still high", awready, 1'b1);
                wdata = ~d;
            end else begin
                chkb("awready low after AW capture", awready, 1'b0);
                chkb("wready still high", wready, 1'b1);
                awaddr = a ^ 32'h4;
            end
            for (int i = 1; i < gap; i++) begin
                @(posedge clk); #1;
                chkb("no bvalid before pair complete", bvalid, 1'b0);
            end
            awvalid = 1'b1; wvalid = 1'b1;
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 300) begin @(posedge clk); #1; lat++; end
        chkb("bvalid arrives", bvalid, 1'b1);
        r = bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chkb("bvalid held under backpressure", bvalid, 1'b1);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chkb("bvalid clears after B handshake", bvalid, 1'b0);
        chkb("awready back", awready, 1'b1);
        chkb("wready back", wready, 1'b1);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        int          order;
        int          gap;
        int          hold;
        logic [1:0]  resp;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                       input int o, input int g, input int h, input logic [1:0] r, input logic [31:0] e);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.order = o;
        v.gap = g; v.hold = h; v.resp = r; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic z_read(input logic [31:0] a, input logic [31:0] e, input logic [1:0] er);
        z_araddr = a; z_arvalid = 1'b1; z_rready = 1'b1;
        @(posedge clk); #1;
        z_arvalid = 1'b0;
        chkb("lat0 rvalid not at handshake", z_rvalid, 1'b0);
        @(posedge clk); #1;
        chkb("lat0 rvalid one cycle after AR", z_rvalid, 1'b1);
        chk("lat0 rdata", z_rdata, e);
        chk("lat0 rresp", 32'(z_rresp), 32'(er));
        @(posedge clk); #1;
        z_rready = 1'b0;
        chkb("lat0 rvalid clears", z_rvalid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] d, a, old_v, new_v;
        logic [1:0]  r;
        int          lat, sel, o, g, h;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chkb("reset arready", arready, 1'b1);
        chkb("reset awready", awready, 1'b1);
        chkb("reset wready", wready, 1'b1);
        chkb("reset rvalid", rvalid, 1'b0);
        chkb("reset bvalid", bvalid, 1'b0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset rresp", 32'(rresp), 32'd0);
        chk("reset bresp", 32'(bresp), 32'd0);

        add(1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, 0, 2'b00, 32'h0);
        add(0, 32'h8000_0010, 32'h0,         8'h00, 0, 0, 0, 2'b00, 32'hDEAD_BEEF);
        add(1, 32'h8000_0010, 32'h0055_0000, 8'h04, 0, 0, 0, 2'b00, 32'h0);
        add(0, 32'h8000_0010, 32'h0,         8'h00, 0, 0, 0, 2'b00, 32'hDE55_BEEF);
        add(1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 0, 0, 0, 2'b00, 32'h0);
        add(0, 32'h8000_0010, 32'h0,         8'h00, 0, 0, 4, 2'b00, 32'hDE55_BEEF);
        add(1, 32'h8000_0014, 32'hCAFE_F00D, 8'h0F, 1, 3, 4, 2'b00, 32'h0);
        add(0, 32'h8000_0014, 32'h0,         8'h00, 0, 0, 0, 2'b00, 32'hCAFE_F00D);
        add(1, 32'h8000_0000, 32'h1111_1111, 8'hFF, 0, 0, 0, 2'b00, 32'h0);
        add(0, 32'h7FFF_FFFC, 32'h0,         8'h00, 0, 0, 0, 2'b11, 32'h0);
        add(1, 32'h8000_1000, 32'h0000_1234, 8'h0F, 0, 0, 0, 2'b11, 32'h0);
        add(0, 32'h8000_0000, 32'h0,         8'h00, 0, 0, 0, 2'b00, 32'h1111_1111);
        add(0, 32'h8000_1000, 32'h0,         8'h00, 0, 0, 0, 2'b11, 32'h0);
        add(1, 32'h8000_0013, 32'h0000_0077, 8'h01, 2, 1, 0, 2'b00, 32'h0);
        add(0, 32'h8000_0012, 32'h0,         8'h00, 0, 0, 2, 2'b00, 32'hDE55_BE77);

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].order, tbl[i].gap,
                          tbl[i].hold, r, lat);
                model_wr(tbl[i].addr, tbl[i].data, tbl[i].strb);
                chk($sformatf("vec%0d bresp", i), 32'(r), 32'(tbl[i].resp));
                chk($sformatf("vec%0d write latency", i), 32'(lat), 32'd3);
            end else begin
                axi_read(tbl[i].addr, tbl[i].hold, d, r, lat);
                chk($sformatf("vec%0d rresp", i), 32'(r), 32'(tbl[i].resp));
                chk($sformatf("vec%0d rdata", i), d, tbl[i].exp);
                chk($sformatf("vec%0d read latency", i), 32'(lat), 32'd3);
            end
        end

        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            axi_write(BASE + 32'(4 * k), d, 8'h0F, 0, 1, 0, r, lat);
            model_wr(BASE + 32'(4 * k), d, 8'h0F);
            chk("prefill bresp", 32'(r), 32'd0);
        end
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 7);
            case ($urandom_range(0, 2))
                0:       a = BASE - 32'd4;
                1:       a = BASE + 32'(4 * DEPTH);
                default: a = 32'h0000_0010;
            endcase
            if (sel != 0) a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            h = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                o = $urandom_range(0, 2);
                g = $urandom_range(1, 3);
                wstrb = 8'($urandom);
                axi_write(a, d, wstrb, o, g, h, r, lat);
                chk($sformatf("rand%0d bresp @%h", n, a), 32'(r), in_rng(a) ? 32'd0 : 32'd3);
                chk($sformatf("rand%0d write latency", n), 32'(lat), 32'd3);
                model_wr(a, d, wstrb);
            end else begin
                axi_read(a, h, d, r, lat);
                chk($sformatf("rand%0d rresp @%h", n, a), 32'(r), in_rng(a) ? 32'd0 : 32'd3);
                chk($sformatf("rand%0d rdata @%h", n, a), d, model_rd(a));
                chk($sformatf("rand%0d read latency", n), 32'(lat), 32'd3);
            end
        end

        // Read sample and write commit on the same edge to the same word.
        old_v = model_rd(BASE + 32'h10);
        new_v = $urandom;
        araddr = BASE + 32'h10; awaddr = BASE + 32'h10; wdata = new_v; wstrb = 8'h0F;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chkb("concurrent rvalid", rvalid, 1'b1);
        chkb("concurrent bvalid", bvalid, 1'b1);
        chk("concurrent read returns old word", rdata, old_v);
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        chkb("concurrent rvalid clears", rvalid, 1'b0);
        chkb("concurrent bvalid clears", bvalid, 1'b0);
        model_wr(BASE + 32'h10, new_v, 8'h0F);
        axi_read(BASE + 32'h10, 0, d, r, lat);
        chk("new word visible after commit", d, new_v);

        // Reset while the read waits.
        araddr = BASE + 32'h4; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chkb("arready right after mid-read reset", arready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chkb("rvalid never rises after reset", rvalid, 1'b0);
            @(posedge clk); #1;
        end
        rready = 1'b0;

        // Reset while the write waits: nothing committed.
        awaddr = BASE + 32'h14; wdata = ~model_rd(BASE + 32'h14); wstrb = 8'h0F;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chkb("awready after mid-write reset", awready, 1'b1);
        chkb("wready after mid-write reset", wready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chkb("bvalid never rises after reset", bvalid, 1'b0);
            @(posedge clk); #1;
        end
        bready = 1'b0;
        axi_read(BASE + 32'h14, 0, d, r, lat);
        chk("dropped write left word intact", d, model_rd(BASE + 32'h14));

        // Zero-latency instance.
        z_awaddr = BASE + 32'hC; z_wdata = 32'hA5A5_0F0F; z_wstrb = 8'hFF;
        z_awvalid = 1'b1; z_wvalid = 1'b1; z_bready = 1'b1;
        @(posedge clk); #1;
        z_awvalid = 1'b0; z_wvalid = 1'b0;
        chkb("lat0 bvalid not at capture", z_bvalid, 1'b0);
        @(posedge clk); #1;
        chkb("lat0 bvalid one cycle after capture", z_bvalid, 1'b1);
        chk("lat0 bresp", 32'(z_bresp), 32'd0);
        @(posedge clk); #1;
        z_bready = 1'b0;
        chkb("lat0 bvalid clears", z_bvalid, 1'b0);
        z_read(BASE + 32'hC, 32'hA5A5_0F0F, 2'b00);
        z_read(BASE + 32'h40, 32'h0, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
